// File: rtl/sm_hex_display.sv
// rtl/sm_hex_display.sv - multiplexed 7-segment scanner with per-frame snapshot and ghost blanking
// Optional leading-zero blanking: SM_HEX_LEADING_ZERO_BLANK_EN
module sm_hex_display #(
   parameter int DIGITS   = 8,
   parameter int SCAN_DIV = 16,
   parameter int GHOST    = 4,
   parameter int AN_LOW   = 1,
   parameter int SEG_LOW  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       value,
   input  logic [7:0]        dotMask,
   output logic [DIGITS-1:0] anodes,
   output logic [6:0]        segments,
   output logic              dot,
   output logic              frameStart
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DIGITS - 1);
   localparam logic [SCAN_DIV-1:0] GHOST_CNT = SCAN_DIV'(GHOST);
   localparam logic [DIGITS-1:0]   AN_OFF    = (AN_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
   localparam logic [6:0]          SEG_OFF   = (SEG_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                DOT_OFF   = (SEG_LOW != 0);
`ifdef SM_HEX_LEADING_ZERO_BLANK_EN
   localparam logic [31:0]         LIVE_MASK = 32'hFFFF_FFFF >> (32 - 4 * DIGITS);
`endif

   logic [SCAN_DIV-1:0] presc_q, presc_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [31:0]         snap_q, snap_d;
   logic [7:0]          dsnap_q, dsnap_d;
   logic [DIGITS-1:0]   anodes_q, anodes_d;
   logic [6:0]          segments_q, segments_d;
   logic                dot_q, dot_d;
   logic                frame_start_q, frame_start_d;

   logic                tick;
   logic                frame_end;
   logic [3:0]          nibble;
   logic [6:0]          seg_raw;
   logic [DIGITS-1:0]   an_raw;
   logic                dot_raw;
`ifdef SM_HEX_LEADING_ZERO_BLANK_EN
   logic [31:0]         upper;
`endif

   always_comb begin
      tick          = &presc_q;
      frame_end     = tick && (idx_q == LAST_IDX);
      presc_d       = presc_q + 1'b1;
      idx_d         = idx_q;
      snap_d        = snap_q;
      dsnap_d       = dsnap_q;
      frame_start_d = frame_end;
      if (tick) begin
         idx_d = frame_end ? '0 : idx_q + 1'b1;
      end
      // The input word is only sampled at the frame boundary so digits never tear.
      if (frame_end) begin
         snap_d  = value;
         dsnap_d = dotMask;
      end

      nibble = snap_q[{idx_q, 2'b00} +: 4];
      case (nibble)
         4'h0: seg_raw = 7'h3F;
         4'h1: seg_raw = 7'h06;
         4'h2: seg_raw = 7'h5B;
         4'h3: seg_raw = 7'h4F;
         4'h4: seg_raw = 7'h66;
         4'h5: seg_raw = 7'h6D;
         4'h6: seg_raw = 7'h7D;
         4'h7: seg_raw = 7'h07;
         4'h8: seg_raw = 7'h7F;
         4'h9: seg_raw = 7'h6F;
         4'hA: seg_raw = 7'h77;
         4'hB: seg_raw = 7'h7C;
         4'hC: seg_raw = 7'h39;
         4'hD: seg_raw = 7'h5E;
         4'hE: seg_raw = 7'h79;
         default: seg_raw = 7'h71;
      endcase
`ifdef SM_HEX_LEADING_ZERO_BLANK_EN
      // Blank a digit when it and everything above it (within the shown width) is zero.
      upper = (snap_q & LIVE_MASK) >> {idx_q, 2'b00};
      if ((idx_q != '0) && (upper == 32'h0)) begin
         seg_raw = 7'h00;
      end
`endif

      an_raw  = (presc_q >= GHOST_CNT) ? (DIGITS'(1) << idx_q) : '0;
      dot_raw = dsnap_q[idx_q];

      anodes_d   = (AN_LOW != 0) ? ~an_raw : an_raw;
      segments_d = (SEG_LOW != 0) ? ~seg_raw : seg_raw;
      dot_d      = (SEG_LOW != 0) ? ~dot_raw : dot_raw;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q       <= '0;
         idx_q         <= '0;
         snap_q        <= '0;
         dsnap_q       <= '0;
         anodes_q      <= AN_OFF;
         segments_q    <= SEG_OFF;
         dot_q         <= DOT_OFF;
         frame_start_q <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         idx_q         <= idx_d;
         snap_q        <= snap_d;
         dsnap_q       <= dsnap_d;
         anodes_q      <= anodes_d;
         segments_q    <= segments_d;
         dot_q         <= dot_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign anodes     = anodes_q;
   assign segments   = segments_q;
   assign dot        = dot_q;
   assign frameStart = frame_start_q;

endmodule
